// File: rtl/trace_chk_pkg.sv
// Shared types for the retirement-trace checker.
// Record layout, checker state encoding and byte-enable mask helper.
package trace_chk_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  wnum;
        logic [31:0] wdata;
        logic [3:0]  we;
    } trace_rec_t;

    localparam int REC_W = $bits(trace_rec_t);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_DONE     = 2'd1,
        ST_ERROR    = 2'd2,
        ST_OVERFLOW = 2'd3
    } chk_state_e;

    function automatic logic [31:0] byte_mask(input logic [3:0] we);
        return {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Generic synchronous FIFO with occupancy count.
// Pointers wrap modulo DEPTH; count spans 0..DEPTH.
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = count == '0;
    assign full    = count == (AW+1)'(DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/wb_trace_checker.sv
// Captures retired register writes and compares them in order
// against a streamed golden trace; latches the first divergence.
module wb_trace_checker
    import trace_chk_pkg::*;
#(
    parameter int          DEPTH  = 8,
    parameter logic [31:0] END_PC = 32'h1c000100
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] debug_wb_pc,
    input  logic [3:0]  debug_wb_rf_we,
    input  logic [4:0]  debug_wb_rf_wnum,
    input  logic [31:0] debug_wb_rf_wdata,
    input  logic        ref_valid,
    output logic        ref_ready,
    input  logic [31:0] ref_pc,
    input  logic [4:0]  ref_wnum,
    input  logic [31:0] ref_wdata,
    output logic [1:0]  chk_state,
    output logic [31:0] pass_cnt,
    output logic [31:0] err_pc,
    output logic [31:0] err_got,
    output logic [31:0] err_exp
);

    localparam int CW = $clog2(DEPTH) + 1;

    chk_state_e       state;
    chk_state_e       state_nxt;
    trace_rec_t       push_rec;
    trace_rec_t       head;
    logic [REC_W-1:0] head_bits;
    logic [CW-1:0]    count;
    logic [31:0]      exp_masked;
    logic running, retire, full, empty, push, pop;
    logic hit, mismatch, overflow, done_cond, end_seen;

    assign running   = state == ST_RUN;
    assign retire    = (debug_wb_rf_we != 4'd0) && (debug_wb_rf_wnum != 5'd0);
    assign ref_ready = running && !empty;
    assign pop       = ref_ready && ref_valid;
    // A full FIFO still accepts a push when the head leaves this cycle.
    assign push      = running && retire && (!full || pop);
    assign overflow  = running && retire && full && !pop;
    assign done_cond = end_seen && (count == '0) && !retire;

    assign push_rec = '{
        pc:    debug_wb_pc,
        wnum:  debug_wb_rf_wnum,
        wdata: debug_wb_rf_wdata & byte_mask(debug_wb_rf_we),
        we:    debug_wb_rf_we
    };

    assign head       = trace_rec_t'(head_bits);
    assign exp_masked = ref_wdata & byte_mask(head.we);
    assign hit        = (head.pc == ref_pc) && (head.wnum == ref_wnum)
                        && (head.wdata == exp_masked);
    assign mismatch   = pop && !hit;
    assign chk_state  = state;

    trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (resetn),
        .push  (push),
        .pop   (pop),
        .wdata (push_rec),
        .rdata (head_bits),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_RUN;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (running) begin
            if (mismatch)       state_nxt = ST_ERROR;
            else if (overflow)  state_nxt = ST_OVERFLOW;
            else if (done_cond) state_nxt = ST_DONE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            end_seen <= 1'b0;
            pass_cnt <= '0;
            err_pc   <= '0;
            err_got  <= '0;
            err_exp  <= '0;
        end else begin
            if (running && retire && debug_wb_pc == END_PC) end_seen <= 1'b1;
            if (pop && hit) pass_cnt <= pass_cnt + 32'd1;
            if (mismatch) begin
                err_pc  <= head.pc;
                err_got <= head.wdata;
                err_exp <= exp_masked;
            end
        end
    end

endmodule

// File: doc/wb_trace_checker.md
# wb_trace_checker

Synthesizable retirement-trace checker sitting directly downstream of `mycpu_top`'s debug write-back port. It captures every architectural register write retired by the CPU into a small FIFO and compares each against a golden reference record streamed in over a valid/ready interface. It latches the first mismatch and flags FIFO overflow and end-of-test, so the core can run unmodified on an FPGA without a simulation-only comparator.

## Interface
Parameters:
- `DEPTH`, 8: capture FIFO depth; power of two, ≥ 2.
- `END_PC`, 32'h1c000100: PC whose retirement marks end of test.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `debug_wb_pc`  in  32  retiring PC from the CPU.
- `debug_wb_rf_we`  in  4  per-byte RF write enable.
- `debug_wb_rf_wnum`  in  5  destination register.
- `debug_wb_rf_wdata`  in  32  written value.
- `ref_valid`  in  1  golden record available.
- `ref_ready`  out  1  golden record consumed this cycle.
- `ref_pc`  in  32  expected PC.
- `ref_wnum`  in  5  expected destination.
- `ref_wdata`  in  32  expected value.
- `chk_state`  out  2  0 RUN, 1 DONE, 2 ERROR, 3 OVERFLOW.
- `pass_cnt`  out  32  matched records.
- `err_pc`  out  32  CPU PC of first mismatch.
- `err_got`  out  32  CPU value, masked.
- `err_exp`  out  32  reference value, masked.

## Operation
- Capture: retire event = `debug_wb_rf_we != 0` and `debug_wb_rf_wnum != 0`. Push {pc, wnum, wdata & mask, we}; mask expands each `we` bit to 8 bits.
- Compare: in RUN, `ref_ready = !empty`, combinational. Handshake = `ref_valid & ref_ready` pops the FIFO. Match iff pc equal, wnum equal and `(ref_wdata & mask) == stored wdata`.
- Match: `pass_cnt` +1, wraps at 2^32.
- Mismatch: go to ERROR and latch `err_pc`, `err_got` and `err_exp`, the last two using the stored mask.
- FSM, starting in RUN:
  - RUN→ERROR on mismatch.
  - RUN→OVERFLOW on push while full with no pop in the same cycle; the record is dropped.
  - RUN→DONE when `end_seen` is set, FIFO empty, and no push this cycle.
  - `end_seen` is a sticky flag set on any cycle with `debug_wb_pc == END_PC` and a retire event.
  - ERROR, OVERFLOW and DONE are terminal until reset. In them, `ref_ready = 0`, pushes are ignored, FIFO and counters are frozen.
- Simultaneous push and pop when full: both happen, no overflow. When empty, a push is not poppable in the same cycle (no bypass).
- Priority in one cycle: mismatch > overflow > done.
- Reset (any time, including mid-compare): FIFO empty, `end_seen = 0`, state RUN, `pass_cnt`/`err_*` = 0, `ref_ready` = 0.

## Timing
- A retire event at edge N is poppable from the cycle after edge N (`ref_ready` high one cycle after capture, given `ref_valid`).
- One pop per cycle maximum; sustained throughput 1 record/cycle.
- `pass_cnt`, `chk_state` and `err_*` update on the edge that completes the handshake; they are visible the following cycle.
- The FIFO occupancy counter is DEPTH+1 states wide (log2(DEPTH)+1 bits). Read and write pointers wrap modulo DEPTH.
- No combinational path from CPU debug inputs to `ref_ready`.

## Structure
- Package `trace_chk_pkg`: `trace_rec_t` (pc 32, wnum 5, wdata 32, we 4 = 73 bits), `chk_state_e` encoding above, `byte_mask()` function.
- Sub-module `trace_fifo`: generic synchronous FIFO (push/pop/full/empty/count), parameterized on width and `DEPTH`, async active-low reset.
- Top-level holds the compare logic, FSM, `end_seen`, counters and error latches.

## Test plan
- Three retirements (pc 1c000000/04/08, r1..r3, we=F) with matching reference records → `pass_cnt=3`, state stays RUN.
- Retire we=4'b0011, wdata 0xDEAD1234; ref_wdata 0xFFFF1234 → match (upper bytes masked), `pass_cnt=1`.
- Second record ref_wdata 0x5 vs CPU 0x6 at pc 1c000004 → ERROR next cycle, `err_pc=1c000004`, `err_got=6`, `err_exp=5`, `ref_ready=0` afterward.
- `ref_valid=0` while 9 retirements occur with DEPTH=8 → OVERFLOW on the 9th; then with full FIFO, push+pop in the same cycle → remains RUN.
- Retire at END_PC, reference drains all records → DONE one cycle after the last pop; wnum=0 writes are never pushed.
- Assert resetn low mid-stream with FIFO at 5 entries → all outputs zero/RUN immediately (async); after release, fresh matches count from 0.
